// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch/jump resolution, fetch redirect
// and wrong-path squash after a taken control transfer.
module ex_mem_stage #(
  parameter int SQUASH_N = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic [31:0] ex_rs2_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_branch,
  input  logic        ex_branch_ne,
  input  logic        ex_jal,
  input  logic        ex_jalr,
  input  logic        mem_stall,
  output logic        mem_valid,
  output logic [31:0] mem_result,
  output logic [31:0] mem_write_data,
  output logic [4:0]  mem_rd,
  output logic        mem_reg_write,
  output logic        mem_mem_read,
  output logic        mem_mem_write,
  output logic        mem_exc,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  localparam int CW = $clog2(SQUASH_N + 1);

  typedef enum logic {NORMAL, SQUASH} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          taken;
  logic          misal;
  logic [31:0]   target;

  assign ex_ready = ~mem_stall;
  assign taken    = (ex_branch & (alu_zero ^ ex_branch_ne))
                  | ex_jal | ex_jalr;
  assign target   = ex_jalr ? (alu_result & ~32'h1)
                            : (ex_pc + ex_imm);
  assign misal    = taken & target[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= NORMAL;
      cnt            <= '0;
      mem_valid      <= 1'b0;
      mem_result     <= '0;
      mem_write_data <= '0;
      mem_rd         <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_exc        <= 1'b0;
      redirect       <= 1'b0;
      redirect_pc    <= '0;
    end else if (mem_stall) begin
      redirect <= 1'b0;
      mem_exc  <= 1'b0;
    end else if (!ex_valid || state == SQUASH) begin
      mem_valid     <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_mem_read  <= 1'b0;
      mem_mem_write <= 1'b0;
      mem_exc       <= 1'b0;
      redirect      <= 1'b0;
      // only accepted wrong-path beats consume the squash budget
      if (ex_valid) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) state <= NORMAL;
      end
    end else begin
      mem_valid      <= 1'b1;
      mem_result     <= (ex_jal | ex_jalr) ? ex_pc + 32'd4
                                           : alu_result;
      mem_write_data <= ex_rs2_data;
      mem_rd         <= ex_rd;
      mem_reg_write  <= ex_reg_write & ~misal;
      mem_mem_read   <= ex_mem_read & ~misal;
      mem_mem_write  <= ex_mem_write & ~misal;
      mem_exc        <= misal;
      redirect       <= taken & ~misal;
      if (taken & ~misal) redirect_pc <= target;
      if (taken) begin
        state <= SQUASH;
        cnt   <= CW'(SQUASH_N);
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed scenarios plus random
// traffic against a queue-based behavioural model.
module tb_ex_mem_stage;

  logic        clk = 0;
  logic        rst = 1;
  logic        ex_valid = 0, ex_ready;
  logic [31:0] ex_pc = 0, ex_imm = 0, alu_result = 0, ex_rs2_data = 0;
  logic        alu_zero = 0;
  logic [4:0]  ex_rd = 0;
  logic        ex_reg_write = 0, ex_mem_read = 0, ex_mem_write = 0;
  logic        ex_branch = 0, ex_branch_ne = 0, ex_jal = 0, ex_jalr = 0;
  logic        mem_stall = 0;
  logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write;
  logic        mem_exc, redirect;
  logic [31:0] mem_result, mem_write_data, redirect_pc;
  logic [4:0]  mem_rd;

  ex_mem_stage #(.SQUASH_N(3)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_imm(ex_imm),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_branch_ne(ex_branch_ne), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
    .mem_stall(mem_stall), .mem_valid(mem_valid),
    .mem_result(mem_result), .mem_write_data(mem_write_data),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_exc(mem_exc), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v, stall, z, rw, mr, mw, br, bne, jal, jalr;
    logic [31:0] pc, imm, alu, rs2;
    logic [4:0] rd;
  } stim_t;

  typedef struct {
    logic ready, valid, rw, mr, mw, exc, redir;
    logic [31:0] result, wdata, rpc;
    logic [4:0] rd;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   squash_left;
  int   checks = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req,
               $time);
    end
  endtask

  function automatic stim_t nop(input logic [31:0] pc);
    stim_t s = '{default: '0};
    s.v = 1; s.pc = pc; s.alu = pc ^ 32'h55; s.rs2 = ~pc;
    s.rd = 5'd3; s.rw = 1;
    return s;
  endfunction

  // Model: one expected output snapshot per clock edge.
  task automatic step(input stim_t s);
    exp_t e;
    logic taken;
    logic [31:0] tgt;
    @(negedge clk);
    ex_valid = s.v; mem_stall = s.stall; ex_pc = s.pc; ex_imm = s.imm;
    alu_result = s.alu; alu_zero = s.z; ex_rs2_data = s.rs2;
    ex_rd = s.rd; ex_reg_write = s.rw; ex_mem_read = s.mr;
    ex_mem_write = s.mw; ex_branch = s.br; ex_branch_ne = s.bne;
    ex_jal = s.jal; ex_jalr = s.jalr;
    e = cur;
    e.ready = !s.stall;
    e.redir = 0;
    e.exc = 0;
    if (s.stall) begin
    end else if (!s.v || squash_left > 0) begin
      e.valid = 0; e.rw = 0; e.mr = 0; e.mw = 0;
      if (s.v) squash_left--;
    end else begin
      if (s.br) taken = (s.bne ? !s.z : s.z);
      else taken = s.jal || s.jalr;
      tgt = s.jalr ? {s.alu[31:1], 1'b0} : s.pc + s.imm;
      e.valid = 1;
      e.result = (s.jal || s.jalr) ? s.pc + 4 : s.alu;
      e.wdata = s.rs2;
      e.rd = s.rd;
      e.exc = taken && tgt[1];
      e.redir = taken && !tgt[1];
      e.rw = s.rw && !e.exc;
      e.mr = s.mr && !e.exc;
      e.mw = s.mw && !e.exc;
      if (e.redir) e.rpc = tgt;
      if (taken) squash_left = 3;
    end
    cur = e;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ex_ready", {31'b0, ex_ready}, {31'b0, e.ready});
        chk("mem_valid", {31'b0, mem_valid}, {31'b0, e.valid});
        chk("mem_reg_write", {31'b0, mem_reg_write}, {31'b0, e.rw});
        chk("mem_mem_read", {31'b0, mem_mem_read}, {31'b0, e.mr});
        chk("mem_mem_write", {31'b0, mem_mem_write}, {31'b0, e.mw});
        chk("mem_exc", {31'b0, mem_exc}, {31'b0, e.exc});
        chk("redirect", {31'b0, redirect}, {31'b0, e.redir});
        if (e.valid) begin
          chk("mem_result", mem_result, e.result);
          chk("mem_write_data", mem_write_data, e.wdata);
          chk("mem_rd", {27'b0, mem_rd}, {27'b0, e.rd});
        end
        if (e.redir) chk("redirect_pc", redirect_pc, e.rpc);
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, " mem_valid"}, {31'b0, mem_valid}, 32'd0);
    chk({tag, " mem_result"}, mem_result, 32'd0);
    chk({tag, " mem_write_data"}, mem_write_data, 32'd0);
    chk({tag, " mem_rd"}, {27'b0, mem_rd}, 32'd0);
    chk({tag, " writes"},
        {29'b0, mem_reg_write, mem_mem_read, mem_mem_write}, 32'd0);
    chk({tag, " mem_exc"}, {31'b0, mem_exc}, 32'd0);
    chk({tag, " redirect"}, {31'b0, redirect}, 32'd0);
    chk({tag, " redirect_pc"}, redirect_pc, 32'd0);
  endtask

  task automatic reset_model();
    cur = '{default: '0};
    squash_left = 0;
    q.delete();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    stim_t s;
    reset_model();
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 0;

    // taken BEQ, then three squashed beats, fourth passes
    s = nop(32'h100); s.br = 1; s.z = 1; s.imm = 32'h20; s.rw = 0;
    step(s);
    for (int i = 0; i < 4; i++) step(nop(32'h104 + 4 * i));

    // BNE with zero, BEQ without zero: not taken
    s = nop(32'h200); s.br = 1; s.bne = 1; s.z = 1; s.imm = 32'h40;
    step(s);
    s = nop(32'h204); s.br = 1; s.z = 0; s.imm = 32'h40;
    step(s);
    for (int i = 0; i < 2; i++) step(nop(32'h208 + 4 * i));

    // JALR aligned, then misaligned
    s = nop(32'h40); s.jalr = 1; s.rd = 1; s.alu = 32'h2001;
    step(s);
    for (int i = 0; i < 3; i++) step(nop(32'h44 + 4 * i));
    s = nop(32'h40); s.jalr = 1; s.rd = 1; s.alu = 32'h2002;
    step(s);
    for (int i = 0; i < 4; i++) step(nop(32'h80 + 4 * i));

    // stall three cycles with JAL presented
    s = nop(32'h300); s.jal = 1; s.imm = 32'h100; s.rd = 1;
    s.stall = 1;
    for (int i = 0; i < 3; i++) step(s);
    s.stall = 0;
    step(s);
    for (int i = 0; i < 4; i++) step(nop(32'h304 + 4 * i));

    // taken BEQ as second beat inside squash window
    s = nop(32'h400); s.jal = 1; s.imm = 32'h8;
    step(s);
    step(nop(32'h404));
    s = nop(32'h408); s.br = 1; s.z = 1; s.imm = 32'h10;
    step(s);
    step(nop(32'h40c));
    for (int i = 0; i < 2; i++) step(nop(32'h500 + 4 * i));

    // async reset mid-squash (two beats left)
    s = nop(32'h600); s.jal = 1; s.imm = 32'h20;
    step(s);
    step(nop(32'h604));
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    check_zero("async_reset");
    ex_valid = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    reset_model();
    step(nop(32'h700));
    step(nop(32'h704));

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      int k;
      s = '{default: '0};
      s.v = ($urandom % 8) != 0;
      s.stall = ($urandom % 5) == 0;
      s.pc = $urandom & ~32'h3;
      s.imm = $urandom & 32'h0000_0ffe;
      s.alu = $urandom;
      s.rs2 = $urandom;
      s.rd = 5'($urandom);
      s.z = 1'($urandom);
      k = $urandom % 5;
      s.rw = 1'($urandom);
      if (k == 0) begin
        s.mr = 1'($urandom);
        s.mw = !s.mr && 1'($urandom);
      end else if (k == 1) begin
        s.br = 1; s.bne = 1'($urandom); s.rw = 0;
      end else if (k == 2) begin
        s.jal = 1;
      end else if (k == 3) begin
        s.jalr = 1;
      end
      step(s);
    end

    @(negedge clk);
    ex_valid = 0;
    mem_stall = 0;
    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected beats left unchecked", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
